// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: frame state encoding and parity type codes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Host/serializer-facing signals of the UART frame controller.
interface uart_tx_fsm_if #(parameter int DATA_WIDTH = 8);
  logic                  Data_valid;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  serial_Data;
  logic                  serial_enable;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output Data_valid, P_DATA, PAR_EN, PAR_TYP, serial_Data,
    input  serial_enable, TX_OUT, busy
  );

  modport slave (
    input  Data_valid, P_DATA, PAR_EN, PAR_TYP, serial_Data,
    output serial_enable, TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_fsm_parity_calc.sv
// Combinational frame parity: XOR reduction of the byte, inverted for odd parity.
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  typ,
  output logic                  par
);
  assign par = (typ == PAR_ODD) ? ~(^data) : (^data);
endmodule

// File: rtl/uart_tx_fsm.sv
// UART TX frame controller: start, LSB-first data, optional parity, stop.
// Outputs are registered from the next-state decode so they line up with the state.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST_n,
  uart_tx_fsm_if.slave  bus
);
  localparam int             CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

  state_e          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            par_en_q, par_bit_q, par_calc;
  logic            tx_q, busy_q, se_q;
  logic            tx_nxt, busy_nxt, se_nxt;
  logic            accept;

  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data (bus.P_DATA),
    .typ  (bus.PAR_TYP),
    .par  (par_calc)
  );

  // A new frame is taken only when the line is idle or on its stop bit.
  assign accept = bus.Data_valid && ((state == IDLE) || (state == STOP));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      cnt       <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        par_en_q  <= bus.PAR_EN;
        par_bit_q <= par_calc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:   if (accept) state_nxt = START;
      START:  state_nxt = DATA;
      DATA: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = par_en_q ? PARITY : STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PARITY: state_nxt = STOP;
      STOP:   state_nxt = accept ? START : IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The serializer is not shifted after the last data bit has been sampled.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = 1'b1;
    se_nxt   = 1'b0;
    case (state_nxt)
      IDLE:   busy_nxt = 1'b0;
      START: begin
        tx_nxt = 1'b0;
        se_nxt = 1'b1;
      end
      DATA: begin
        tx_nxt = bus.serial_Data;
        se_nxt = (cnt_nxt != LAST);
      end
      PARITY: tx_nxt = par_bit_q;
      STOP:   ;
      default: busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      tx_q   <= tx_nxt;
      busy_q <= busy_nxt;
      se_q   <= se_nxt;
    end
  end

  assign bus.TX_OUT        = tx_q;
  assign bus.busy          = busy_q;
  assign bus.serial_enable = se_q;

endmodule
